// File: rtl/div_param.sv
// div_param: multi-cycle radix-2 restoring divider with signed/unsigned modes,
// divide-by-zero flag, annul and busy/ready handshake.
module div_param #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_by_zero_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
    state_t state;
    logic [WIDTH-1:0] dvd, dvs, rem, abs1, abs2, quo_fix, rem_fix;
    logic [CW-1:0] cnt;
    logic neg_q, neg_r;
    logic [WIDTH:0] trial, diff;
    always_comb begin
        abs1 = signed_div_i && opdata1_i[WIDTH-1] ? -opdata1_i : opdata1_i;
        abs2 = signed_div_i && opdata2_i[WIDTH-1] ? -opdata2_i : opdata2_i;
        trial = {rem, dvd[WIDTH-1]};
        diff = trial - {1'b0, dvs};
        quo_fix = neg_q ? -dvd : dvd;
        rem_fix = neg_r ? -rem : rem;
    end
    // dvd doubles as the quotient shift register: quotient bits enter at the LSB
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            result_o <= '0;
            ready_o <= 1'b0;
            busy_o <= 1'b0;
            div_by_zero_o <= 1'b0;
            dvd <= '0;
            dvs <= '0;
            rem <= '0;
            cnt <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i && !annul_i) begin
                    dvd <= abs1;
                    dvs <= abs2;
                    rem <= '0;
                    cnt <= '0;
                    neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_r <= signed_div_i && opdata1_i[WIDTH-1];
                    busy_o <= 1'b1;
                    state <= opdata2_i == '0 ? BYZERO : ON;
                end
                BYZERO: begin
                    busy_o <= 1'b0;
                    if (annul_i) state <= IDLE;
                    else begin
                        state <= END;
                        ready_o <= 1'b1;
                        div_by_zero_o <= 1'b1;
                        result_o <= '0;
                    end
                end
                ON: if (annul_i) begin
                    state <= IDLE;
                    busy_o <= 1'b0;
                end else if (cnt == CW'(WIDTH)) begin
                    result_o <= {rem_fix, quo_fix};
                    ready_o <= 1'b1;
                    busy_o <= 1'b0;
                    state <= END;
                end else begin
                    cnt <= cnt + 1'b1;
                    rem <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
                end
                END: if (!start_i) begin
                    state <= IDLE;
                    ready_o <= 1'b0;
                    result_o <= '0;
                    div_by_zero_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_param.sv
// tb_div_param: scoreboard bench for div_param at WIDTH=32 and WIDTH=8.
module tb_div_param;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic s32 = 0, st32 = 0, an32 = 0, rdy32, bsy32, dz32;
    logic [31:0] a32 = 0, b32 = 0;
    logic [63:0] r32;
    logic s8 = 0, st8 = 0, an8 = 0, rdy8, bsy8, dz8;
    logic [7:0] a8 = 0, b8 = 0;
    logic [15:0] r8;
    logic [64:0] sb[$];
    int n_chk = 0, n_pass = 0;

    div_param #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .signed_div_i(s32), .opdata1_i(a32),
        .opdata2_i(b32), .start_i(st32), .annul_i(an32), .result_o(r32), .ready_o(rdy32),
        .busy_o(bsy32), .div_by_zero_o(dz32));
    div_param #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .signed_div_i(s8), .opdata1_i(a8),
        .opdata2_i(b8), .start_i(st8), .annul_i(an8), .result_o(r8), .ready_o(rdy8),
        .busy_o(bsy8), .div_by_zero_o(dz8));

    // {div_by_zero, remainder, quotient}, computed with 64-bit arithmetic so the
    // most-negative / -1 case wraps without overflowing the model
    function automatic logic [64:0] model(int w, logic [31:0] a, logic [31:0] b, logic s);
        longint m = (longint'(1) << w) - 1;
        longint x = longint'(a) & m;
        longint y = longint'(b) & m;
        if (y == 0) return {1'b1, 64'd0};
        if (s && x[w-1]) x -= m + 1;
        if (s && y[w-1]) y -= m + 1;
        return {1'b0, 64'((((x % y) & m) << w) | ((x / y) & m))};
    endfunction

    function automatic logic [64:0] obs(int w);
        return w == 8 ? {dz8, 48'd0, r8} : {dz32, r32};
    endfunction

    function automatic logic [1:0] hs(int w);
        return w == 8 ? {rdy8, bsy8} : {rdy32, bsy32};
    endfunction

    task automatic check(string tag, logic [64:0] o, logic [64:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, o, e);
    endtask

    task automatic run(int w, logic [31:0] a, logic [31:0] b, logic s, bit scramble);
        logic [64:0] e;
        int lat = 0, bc = 0;
        bit dz;
        @(negedge clk);
        if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; s8 = s; st8 = 1; end
        else begin a32 = a; b32 = b; s32 = s; st32 = 1; end
        sb.push_back(model(w, a, b, s));
        dz = w == 8 ? b[7:0] == 0 : b == 0;
        do begin
            @(negedge clk);
            lat++;
            if (hs(w)[0]) bc++;
            if (scramble && w == 32) begin
                a32 = $urandom; b32 = $urandom; s32 = ~s32; st32 = ~st32;
            end
        end while (!hs(w)[1] && lat < 200);
        e = sb.pop_front();
        check("latency", 65'(lat), dz ? 65'd2 : 65'(w + 2));
        check("busy_cycles", 65'(bc), dz ? 65'd1 : 65'(w + 1));
        check("result", obs(w), e);
        st8 = 0; st32 = 0;
        @(negedge clk);
        check("back_to_idle", {hs(w), obs(w)}, 67'd0);
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        check("reset32", {rdy32, bsy32, dz32, r32}, 67'd0);
        check("reset8", {rdy8, bsy8, dz8, 48'd0, r8}, 67'd0);
        rst = 0;
        run(32, 100, 7, 0, 0);
        run(32, 32'hFFFFFFF9, 2, 1, 0);
        run(32, 7, 32'hFFFFFFFE, 1, 0);
        run(32, 32'h12345678, 0, 0, 0);
        run(32, 32'h80000000, 0, 1, 0);
        run(32, 32'h80000000, 32'hFFFFFFFF, 1, 0);
        run(32, 32'h80000000, 3, 0, 0);
        run(8, 8'h80, 8'hFF, 1, 0);
        run(8, 8'hFF, 8'h10, 0, 0);
        run(8, 8'h85, 8'h07, 1, 0);
        run(8, 8'h80, 8'hFF, 0, 0);
        run(8, 8'h05, 0, 1, 0);
        // annul held in IDLE must block the start request
        @(negedge clk); an32 = 1; st32 = 1; a32 = 9; b32 = 3;
        repeat (2) @(negedge clk);
        check("annul_blocks_start", {30'd0, hs(32)}, 32'd0);
        an32 = 0; st32 = 0;
        // annul at iteration 10
        @(negedge clk); a32 = 1000; b32 = 3; s32 = 0; st32 = 1;
        repeat (11) @(negedge clk);
        an32 = 1;
        @(negedge clk); an32 = 0; st32 = 0;
        check("annul_idle", {hs(32), obs(32)}, 67'd0);
        seen = 0;
        repeat (40) begin @(negedge clk); if (rdy32) seen = 1; end
        check("annul_no_ready", 65'(seen), 65'd0);
        run(32, 50, 5, 0, 0);
        // reset at iteration 5
        @(negedge clk); a32 = 12345; b32 = 17; s32 = 0; st32 = 1;
        repeat (6) @(negedge clk);
        rst = 1;
        @(negedge clk); rst = 0; st32 = 0;
        check("reset_mid_op", {hs(32), obs(32)}, 67'd0);
        seen = 0;
        repeat (40) begin @(negedge clk); if (rdy32) seen = 1; end
        check("reset_no_ready", 65'(seen), 65'd0);
        run(32, 32'hDEADBEEF, 32'h1234, 0, 1);
        run(32, 32'hDEADBEEF, 32'h1234, 1, 1);
        // annul in END is ignored
        @(negedge clk); a32 = 77; b32 = 10; s32 = 0; st32 = 1;
        repeat (34) @(negedge clk);
        an32 = 1;
        @(negedge clk); an32 = 0;
        check("annul_in_end", obs(32), model(32, 77, 10, 0));
        st32 = 0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            run(32, $urandom, $urandom_range(1, 1000), 1'($urandom), 0);
            run(8, $urandom, $urandom, 1'($urandom), 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
